control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_ctrl_pkg.sv | 66 ++++++
 rtl/ctrl_step_decode.sv | 87 ++++++++
 rtl/control_unit.sv | 85 ++++++++
 tb/tb_control_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode, state-encoding and control-word definitions for the
// hardwired CPU control unit.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_T0    = 4'd1;
  localparam logic [3:0] S_T1    = 4'd2;
  localparam logic [3:0] S_T2    = 4'd3;
  localparam logic [3:0] S_T3    = 4'd4;
  localparam logic [3:0] S_T4    = 4'd5;
  localparam logic [3:0] S_T5    = 4'd6;
  localparam logic [3:0] S_T6    = 4'd7;
  localparam logic [3:0] S_T7    = 4'd8;
  localparam logic [3:0] S_HALT  = 4'd9;

  typedef struct packed {
    logic pc_out, pc_in, inc_pc;
    logic mar_in, mdr_in, mdr_out, read, ram_wr_enable;
    logic ir_in, y_in, zhi_in, zlo_in, zhigh_out, zlow_out;
    logic hi_in, lo_in, hi_out, lo_out;
    logic gra, grb, grc, r_in, r_out, ba_out, c_out;
    logic con_in, in_port_out, enable_out_port;
  } ctrl_word_t;

  // Final step of each instruction class; undefined opcodes end after fetch like nop.
  function automatic logic [3:0] last_step(input logic [4:0] op);
    case (op)
      OP_LD, OP_ST:                         last_step = S_T7;
      OP_MUL, OP_DIV, OP_BR:                last_step = S_T6;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:     last_step = S_T5;
      OP_NEG, OP_NOT:                       last_step = S_T4;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: last_step = S_T3;
      default:                              last_step = S_T2;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_step_decode.sv
// Combinational Moore decode of the current step and opcode into the
// datapath control word.
module ctrl_step_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [4:0] opcode,
  input  logic       con_ff,
  output ctrl_word_t ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_T0: begin ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; end
      S_T1: begin ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
      S_T2: begin ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1; end
      S_T3: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
          OP_ADDI, OP_ANDI, OP_ORI: begin
            ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
          end
          OP_LDI, OP_LD, OP_ST: begin
            ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
          end
          OP_MUL, OP_DIV: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
          OP_NEG, OP_NOT: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.zlo_in = 1'b1; end
          OP_BR:   begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1; end
          OP_JR:   begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
          OP_IN:   begin ctrl.in_port_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          OP_OUT:  begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.enable_out_port = 1'b1; end
          OP_MFHI: begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          OP_MFLO: begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
            ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.zlo_in = 1'b1;
          end
          OP_ADDI, OP_ANDI, OP_ORI, OP_LDI, OP_LD, OP_ST: begin
            ctrl.c_out = 1'b1; ctrl.zlo_in = 1'b1;
          end
          OP_MUL, OP_DIV: begin
            ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.zhi_in = 1'b1; ctrl.zlo_in = 1'b1;
          end
          OP_NEG, OP_NOT: begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          OP_BR:          begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
          OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin
            ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
          end
          OP_LD, OP_ST:   begin ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1; end
          OP_MUL, OP_DIV: begin ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1; end
          OP_BR:          begin ctrl.c_out = 1'b1; ctrl.zlo_in = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (opcode)
          OP_LD:          begin ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
          OP_ST:          begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1; end
          OP_MUL, OP_DIV: begin ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1; end
          // Branch target is only committed to the PC when the condition held.
          OP_BR: begin ctrl.zlow_out = con_ff; ctrl.pc_in = con_ff; end
          default: ;
        endcase
      end
      S_T7: begin
        case (opcode)
          OP_LD:   begin ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          OP_ST:   ctrl.ram_wr_enable = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit: step-state register and sequencing; output
// decode is delegated to ctrl_step_decode.
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        stop,
  output logic        Run,
  output logic        PCout, PCin, IncPC,
  output logic        MARin, MDRin, MDRout, Read, RAM_wr_enable,
  output logic        IRin, Yin, ZHIin, ZLOin, ZHighout, ZLowout,
  output logic        HIin, LOin, HIout, LOout,
  output logic        GRA, GRB, GRC, R_in, R_out, Baout, Cout,
  output logic        CONin, InPortout, enable_outPort
);

  logic [3:0] state, next_state;
  logic [4:0] opcode;
  ctrl_word_t ctrl;
  logic       unused_ir_bits;

  assign opcode         = IR[31:27];
  assign unused_ir_bits = ^IR[26:0];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= S_RESET;
    else      state <= next_state;
  end

  // Every entry into T0 is an instruction boundary where a pending stop diverts to HALT.
  always_comb begin
    next_state = S_RESET;
    case (state)
      S_RESET: next_state = stop ? S_HALT : S_T0;
      S_HALT:  next_state = S_HALT;
      S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (state == S_T2 && opcode == OP_HALT) next_state = S_HALT;
        else if (state == last_step(opcode))    next_state = stop ? S_HALT : S_T0;
        else                                    next_state = state + 4'd1;
      end
      default: next_state = S_RESET;
    endcase
  end

  ctrl_step_decode u_decode (
    .state  (state),
    .opcode (opcode),
    .con_ff (CON_FF),
    .ctrl   (ctrl)
  );

  assign Run            = (state != S_RESET) && (state != S_HALT);
  assign PCout          = ctrl.pc_out;
  assign PCin           = ctrl.pc_in;
  assign IncPC          = ctrl.inc_pc;
  assign MARin          = ctrl.mar_in;
  assign MDRin          = ctrl.mdr_in;
  assign MDRout         = ctrl.mdr_out;
  assign Read           = ctrl.read;
  assign RAM_wr_enable  = ctrl.ram_wr_enable;
  assign IRin           = ctrl.ir_in;
  assign Yin            = ctrl.y_in;
  assign ZHIin          = ctrl.zhi_in;
  assign ZLOin          = ctrl.zlo_in;
  assign ZHighout       = ctrl.zhigh_out;
  assign ZLowout        = ctrl.zlow_out;
  assign HIin           = ctrl.hi_in;
  assign LOin           = ctrl.lo_in;
  assign HIout          = ctrl.hi_out;
  assign LOout          = ctrl.lo_out;
  assign GRA            = ctrl.gra;
  assign GRB            = ctrl.grb;
  assign GRC            = ctrl.grc;
  assign R_in           = ctrl.r_in;
  assign R_out          = ctrl.r_out;
  assign Baout          = ctrl.ba_out;
  assign Cout           = ctrl.c_out;
  assign CONin          = ctrl.con_in;
  assign InPortout      = ctrl.in_port_out;
  assign enable_outPort = ctrl.enable_out_port;

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven bench for control_unit: per-step control sets for
// each instruction class plus halt, stop and mid-instruction reset sequences.
module tb_control_unit;

  localparam logic [27:0] PCOUT  = 28'd1 << 0;
  localparam logic [27:0] PCIN   = 28'd1 << 1;
  localparam logic [27:0] INCPC  = 28'd1 << 2;
  localparam logic [27:0] MARIN  = 28'd1 << 3;
  localparam logic [27:0] MDRIN  = 28'd1 << 4;
  localparam logic [27:0] MDROUT = 28'd1 << 5;
  localparam logic [27:0] READ   = 28'd1 << 6;
  localparam logic [27:0] RAMWR  = 28'd1 << 7;
  localparam logic [27:0] IRIN   = 28'd1 << 8;
  localparam logic [27:0] YIN    = 28'd1 << 9;
  localparam logic [27:0] ZHIIN  = 28'd1 << 10;
  localparam logic [27:0] ZLOIN  = 28'd1 << 11;
  localparam logic [27:0] ZHIOUT = 28'd1 << 12;
  localparam logic [27:0] ZLOOUT = 28'd1 << 13;
  localparam logic [27:0] HIIN   = 28'd1 << 14;
  localparam logic [27:0] LOIN   = 28'd1 << 15;
  localparam logic [27:0] HIOUT  = 28'd1 << 16;
  localparam logic [27:0] LOOUT  = 28'd1 << 17;
  localparam logic [27:0] GRA_B  = 28'd1 << 18;
  localparam logic [27:0] GRB_B  = 28'd1 << 19;
  localparam logic [27:0] GRC_B  = 28'd1 << 20;
  localparam logic [27:0] RIN    = 28'd1 << 21;
  localparam logic [27:0] ROUT   = 28'd1 << 22;
  localparam logic [27:0] BAOUT  = 28'd1 << 23;
  localparam logic [27:0] COUT   = 28'd1 << 24;
  localparam logic [27:0] CONIN  = 28'd1 << 25;
  localparam logic [27:0] INPORT = 28'd1 << 26;
  localparam logic [27:0] OUTEN  = 28'd1 << 27;

  localparam logic [27:0] F0 = PCOUT | MARIN | INCPC;
  localparam logic [27:0] F1 = READ | MDRIN;
  localparam logic [27:0] F2 = MDROUT | IRIN;

  typedef struct {
    string            name;
    logic [4:0]       op;
    logic             con;
    int               len;
    logic [7:0][27:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        clr, CON_FF, stop;
  logic [31:0] IR;
  logic        Run;
  logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, RAM_wr_enable;
  logic        IRin, Yin, ZHIin, ZLOin, ZHighout, ZLowout, HIin, LOin, HIout, LOout;
  logic        GRA, GRB, GRC, R_in, R_out, Baout, Cout, CONin, InPortout, enable_outPort;
  logic [27:0] act;

  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .clr(clr), .IR(IR), .CON_FF(CON_FF), .stop(stop), .Run(Run),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .RAM_wr_enable(RAM_wr_enable),
    .IRin(IRin), .Yin(Yin), .ZHIin(ZHIin), .ZLOin(ZLOin), .ZHighout(ZHighout), .ZLowout(ZLowout),
    .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
    .GRA(GRA), .GRB(GRB), .GRC(GRC), .R_in(R_in), .R_out(R_out), .Baout(Baout), .Cout(Cout),
    .CONin(CONin), .InPortout(InPortout), .enable_outPort(enable_outPort)
  );

  assign act = {enable_outPort, InPortout, CONin, Cout, Baout, R_out, R_in, GRC, GRB, GRA,
                LOout, HIout, LOin, HIin, ZLowout, ZHighout, ZLOin, ZHIin, Yin, IRin,
                RAM_wr_enable, Read, MDRout, MDRin, MARin, IncPC, PCin, PCout};

  task automatic applyStimulus(input logic [4:0] op, input logic con, input logic stp);
    IR     = {op, 27'h0A5A5A5};
    CON_FF = con;
    stop   = stp;
  endtask

  task automatic checkOutput(input string nm, input logic [27:0] e, input logic er);
    checks++;
    if ({Run, act} !== {er, e}) begin
      errors++;
      $display("[TB] FAIL %s: got Run=%b ctrl=%07h, expected Run=%b ctrl=%07h",
               nm, Run, act, er, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic addVec(input string nm, input logic [4:0] op, input logic con, input int len,
                        input logic [27:0] e3, input logic [27:0] e4, input logic [27:0] e5,
                        input logic [27:0] e6, input logic [27:0] e7);
    vec_t v;
    v.name = nm;
    v.op   = op;
    v.con  = con;
    v.len  = len;
    v.exp  = {e7, e6, e5, e4, e3, F2, F1, F0};
    vecs.push_back(v);
  endtask

  // Entered at a negedge; leaves the bench at the negedge of the first T0.
  task automatic doReset(input string nm);
    clr = 1'b0;
    #1 checkOutput({nm, "_async"}, 28'd0, 1'b0);
    @(negedge clk);
    checkOutput({nm, "_held"}, 28'd0, 1'b0);
    clr = 1'b1;
    tick();
    checkOutput({nm, "_first_T0"}, F0, 1'b1);
  endtask

  task automatic checkHalted(input string nm, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      checkOutput($sformatf("%s_halt%0d", nm, i), 28'd0, 1'b0);
      tick();
    end
  endtask

  initial begin
    clr = 1'b0;
    applyStimulus(5'b00011, 1'b0, 1'b0);

    addVec("add",   5'b00011, 0, 6, GRB_B|ROUT|YIN, GRC_B|ROUT|ZLOIN, ZLOOUT|GRA_B|RIN, 0, 0);
    addVec("shra",  5'b01010, 0, 6, GRB_B|ROUT|YIN, GRC_B|ROUT|ZLOIN, ZLOOUT|GRA_B|RIN, 0, 0);
    addVec("addi",  5'b01100, 0, 6, GRB_B|ROUT|YIN, COUT|ZLOIN, ZLOOUT|GRA_B|RIN, 0, 0);
    addVec("ldi",   5'b00001, 0, 6, GRB_B|ROUT|BAOUT|YIN, COUT|ZLOIN, ZLOOUT|GRA_B|RIN, 0, 0);
    addVec("ld",    5'b00000, 0, 8, GRB_B|ROUT|BAOUT|YIN, COUT|ZLOIN, ZLOOUT|MARIN,
           READ|MDRIN, MDROUT|GRA_B|RIN);
    addVec("st",    5'b00010, 0, 8, GRB_B|ROUT|BAOUT|YIN, COUT|ZLOIN, ZLOOUT|MARIN,
           GRA_B|ROUT|MDRIN, RAMWR);
    addVec("mul",   5'b10000, 0, 7, GRA_B|ROUT|YIN, GRB_B|ROUT|ZHIIN|ZLOIN, ZLOOUT|LOIN,
           ZHIOUT|HIIN, 0);
    addVec("div",   5'b01111, 0, 7, GRA_B|ROUT|YIN, GRB_B|ROUT|ZHIIN|ZLOIN, ZLOOUT|LOIN,
           ZHIOUT|HIIN, 0);
    addVec("neg",   5'b10001, 0, 5, GRB_B|ROUT|ZLOIN, ZLOOUT|GRA_B|RIN, 0, 0, 0);
    addVec("br_c0", 5'b10011, 0, 7, GRA_B|ROUT|CONIN, PCOUT|YIN, COUT|ZLOIN, 0, 0);
    addVec("br_c1", 5'b10011, 1, 7, GRA_B|ROUT|CONIN, PCOUT|YIN, COUT|ZLOIN, ZLOOUT|PCIN, 0);
    addVec("jr",    5'b10100, 0, 4, GRA_B|ROUT|PCIN, 0, 0, 0, 0);
    addVec("in",    5'b10110, 0, 4, INPORT|GRA_B|RIN, 0, 0, 0, 0);
    addVec("out",   5'b10111, 0, 4, GRA_B|ROUT|OUTEN, 0, 0, 0, 0);
    addVec("mfhi",  5'b11000, 0, 4, HIOUT|GRA_B|RIN, 0, 0, 0, 0);
    addVec("mflo",  5'b11001, 0, 4, LOOUT|GRA_B|RIN, 0, 0, 0, 0);
    addVec("nop",   5'b11010, 0, 3, 0, 0, 0, 0, 0);
    addVec("undef", 5'b11111, 0, 3, 0, 0, 0, 0, 0);
    addVec("add2",  5'b00011, 1, 6, GRB_B|ROUT|YIN, GRC_B|ROUT|ZLOIN, ZLOOUT|GRA_B|RIN, 0, 0);

    #1 checkOutput("reset_state", 28'd0, 1'b0);
    @(negedge clk);
    checkOutput("reset_after_edge", 28'd0, 1'b0);
    clr = 1'b1;
    tick();

    // Instructions run back to back; each one's T0 check also verifies the previous return.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].con, 1'b0);
      for (int k = 0; k < vecs[i].len; k++) begin
        checkOutput($sformatf("%s_T%0d", vecs[i].name, k), vecs[i].exp[k[2:0]], 1'b1);
        tick();
      end
    end
    checkOutput("final_return_T0", F0, 1'b1);

    applyStimulus(5'b11011, 1'b0, 1'b0);
    checkOutput("halt_T0", F0, 1'b1);
    tick();
    checkOutput("halt_T1", F1, 1'b1);
    tick();
    checkOutput("halt_T2", F2, 1'b1);
    tick();
    checkHalted("halt_op", 20);
    applyStimulus(5'b00011, 1'b0, 1'b0);
    doReset("halt_reset");

    applyStimulus(5'b10000, 1'b0, 1'b0);
    checkOutput("mulstop_T0", F0, 1'b1);
    tick();
    checkOutput("mulstop_T1", F1, 1'b1);
    tick();
    checkOutput("mulstop_T2", F2, 1'b1);
    tick();
    checkOutput("mulstop_T3", GRA_B|ROUT|YIN, 1'b1);
    tick();
    checkOutput("mulstop_T4", GRB_B|ROUT|ZHIIN|ZLOIN, 1'b1);
    stop = 1'b1;
    tick();
    checkOutput("mulstop_T5", ZLOOUT|LOIN, 1'b1);
    tick();
    checkOutput("mulstop_T6", ZHIOUT|HIIN, 1'b1);
    tick();
    checkHalted("mulstop", 20);
    stop = 1'b0;
    doReset("stop_reset");

    applyStimulus(5'b00010, 1'b0, 1'b0);
    checkOutput("stabort_T0", F0, 1'b1);
    tick();
    checkOutput("stabort_T1", F1, 1'b1);
    tick();
    checkOutput("stabort_T2", F2, 1'b1);
    tick();
    checkOutput("stabort_T3", GRB_B|ROUT|BAOUT|YIN, 1'b1);
    tick();
    checkOutput("stabort_T4", COUT|ZLOIN, 1'b1);
    tick();
    checkOutput("stabort_T5", ZLOOUT|MARIN, 1'b1);
    tick();
    checkOutput("stabort_T6", GRA_B|ROUT|MDRIN, 1'b1);
    #2 clr = 1'b0;
    #1 checkOutput("stabort_async", 28'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput($sformatf("stabort_held%0d", i), 28'd0, 1'b0);
    end
    clr = 1'b1;
    tick();
    checkOutput("stabort_release_T0", F0, 1'b1);
    tick();
    checkOutput("stabort_release_T1", F1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
